pwm_output_stage: RTL and testbench
===================================

# pwm_output_stage

Consumes the five configuration registers written by the SPI register file and drives the 16 chip outputs. Each bit is off, statically on, or modulated by one shared 8-bit PWM waveform. The PWM runs from a clock prescaler and has a 256-step period. All outputs are registered, so pins never see combinational glitches.

## Interface
Parameters:
- CLK_DIV, 3000: system clocks per PWM step (≥1). At a 10 MHz clk this gives ≈13 Hz per 256-step period.

Ports:
- clk  input  1  system clock; one clock domain, posedge only
- rst_n  input  1  asynchronous, active-low reset
- en_reg_out_7_0  input  8  output enable, bits 7:0
- en_reg_out_15_8  input  8  output enable, bits 15:8
- en_reg_pwm_7_0  input  8  PWM-mode select, bits 7:0
- en_reg_pwm_15_8  input  8  PWM-mode select, bits 15:8
- pwm_duty_cycle  input  8  duty value, 0x00–0xFF
- out  output  16  registered chip outputs
- period_strobe  output  1  one-clk pulse on the cycle the step counter wraps 255→0

## Operation
- Prescaler div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick is high on the cycle div_cnt == CLK_DIV-1.
  - CLK_DIV = 1 makes tick permanently high.
- Step counter step_cnt (8 bits) increments on tick and wraps 255→0 unchecked.
- Waveform: pwm_level = (duty_eff == 8'hFF) | (step_cnt < duty_eff), unsigned compare.
  - 0x00 gives 0 %.
  - 0xFF gives 100 %, a special case with no single-step gap.
  - Any other N gives N/256 high.
- Per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - next out[i] = en_out[i] & (en_pwm[i] ? pwm_level : 1'b1).
  - en_out = 0 always forces 0, whatever en_pwm is.
- period_strobe is registered. It is high for exactly one clk, the cycle after the one where tick & step_cnt == 255.
- Register inputs arrive already in the clk domain. No synchronisers here.

## Timing
- Reset (async assert, sync to clk on release): out = 0, period_strobe = 0, div_cnt = 0, step_cnt = 0, duty shadow = 0.
- Reset asserted mid-period zeroes everything immediately. After release, counting restarts from step 0.
- Latency:
  - A change on en_* reaches out one clk later.
  - A change in step_cnt reaches out one clk later.
- Duty update point: see Configuration.
- Simultaneous events:
  - On a wrap tick, step_cnt→0, the shadow load and the strobe all occur on the same edge.
  - out on the following cycle uses step 0 and the new duty.

## Configuration
- Macro PWM_SHADOW_EN.
- Defined: duty_eff is a shadow register.
  - Loaded from pwm_duty_cycle only on the wrap edge (tick & step_cnt == 255).
  - Mid-period writes take effect at the next period start, giving glitch-free periods.
  - Until the first wrap after reset, duty_eff = 0.
- Undefined: duty_eff = pwm_duty_cycle, used live.
  - A mid-period change applies to the compare on the next clk.
  - A shortened or lengthened period is accepted.

## Structure
- Package pwm_pkg holds:
  - PWM_STEP_W = 8
  - PWM_DUTY_FULL = 8'hFF
  - PWM_CHANNELS = 16
- Sub-module pwm_prescaler(clk, rst_n → tick), parameterised by CLK_DIV. Its counter width is $clog2(CLK_DIV), minimum 1.
- Top level holds step_cnt, the duty shadow, the compare, and the 16-bit output register.

## Test plan
- Reset: hold rst_n = 0 with all inputs = 0xFF → out = 0x0000 and period_strobe = 0. Release → out = 0xFFFF within 2 clks (unshadowed build).
- Static on: en_out = 0xA5C3, en_pwm = 0 → out = 0xA5C3 one clk after the write; no toggling over 3 periods.
- Duty sweep: CLK_DIV = 4, en_out = en_pwm = 0xFFFF.
  - Duty 0x00 → out stays 0.
  - Duty 0x80 → each bit high for exactly 512 of 1024 clks.
  - Duty 0xFF → out stays 0xFFFF.
- Mode mix: en_out = 0x00FF, en_pwm = 0x0F0F, duty 0x40, CLK_DIV = 1.
  - Bits 3:0 are high for 64 of 256 clks.
  - Bits 7:4 are constant 1.
  - Bits 15:8 are 0 (bits 11:8 stay 0 despite en_pwm).
- Shadow (PWM_SHADOW_EN): duty 0x20, then 0xE0 written at step 100 → the current period stays at 32 high steps; the next period has 224. period_strobe pulses once per 256·CLK_DIV clks.
- Reset mid-period at step 150: out = 0 immediately (async). After release, step_cnt restarts at 0 and the first period_strobe arrives 256·CLK_DIV clks later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths and the PWM compare rule for the output stage.
// Pure definitions; no timing or flow control of its own.
// Nothing here applies backpressure.
package pwm_pkg;
    localparam int PWM_STEP_W   = 8;
    localparam logic [PWM_STEP_W-1:0] PWM_DUTY_FULL = 8'hFF;
    localparam int PWM_CHANNELS = 16;

    // Full-scale duty is special-cased so 0xFF has no single-step low gap.
    function automatic logic pwm_compare(input logic [PWM_STEP_W-1:0] step,
                                         input logic [PWM_STEP_W-1:0] duty);
        return (duty == PWM_DUTY_FULL) || (step < duty);
    endfunction
endpackage

// File: rtl/pwm_output_stage_if.sv
// Register-file to output-stage bundle: enable/mode/duty in, pins and strobe out.
// Levels only; the output stage registers everything it drives.
// No handshake: registers are static levels, so there is no backpressure.
interface pwm_output_stage_if;
    import pwm_pkg::*;

    logic [7:0]              en_reg_out_7_0;
    logic [7:0]              en_reg_out_15_8;
    logic [7:0]              en_reg_pwm_7_0;
    logic [7:0]              en_reg_pwm_15_8;
    logic [PWM_STEP_W-1:0]   pwm_duty_cycle;
    logic [PWM_CHANNELS-1:0] out;
    logic                    period_strobe;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out, period_strobe
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out, period_strobe
    );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick is high one clk in every CLK_DIV (always high when CLK_DIV = 1).
// tick is combinational from the counter, valid the same cycle.
// Free-running; no backpressure.
module pwm_prescaler #(
    parameter int CLK_DIV = 3000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick = (div_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pwm_output_stage.sv
// Drives 16 pins off / on / PWM from one shared 256-step waveform; PWM_SHADOW_EN shadows duty per period.
// Latency: one clk from enable, mode, step or (unshadowed) duty change to pins.
// No backpressure: register inputs are sampled every clk.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 3000
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_output_stage_if.slave  bus
);
    logic                    tick;
    logic                    wrap;
    logic [PWM_STEP_W-1:0]   step_cnt;
    logic [PWM_STEP_W-1:0]   duty_eff;
    logic                    pwm_level;
    logic [PWM_CHANNELS-1:0] en_out;
    logic [PWM_CHANNELS-1:0] en_pwm;
    logic [PWM_CHANNELS-1:0] out_nxt;

    pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Step wrap, strobe and shadow load all land on this one edge.
    assign wrap = tick && (step_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= step_cnt + PWM_STEP_W'(1);
        end
    end

`ifdef PWM_SHADOW_EN
    logic [PWM_STEP_W-1:0] duty_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= '0;
        end else if (wrap) begin
            duty_shadow <= bus.pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_shadow;
`else
    assign duty_eff = bus.pwm_duty_cycle;
`endif

    assign pwm_level = pwm_compare(step_cnt, duty_eff);
    assign en_out    = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm    = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Disabled bits stay low regardless of mode; static bits ignore the waveform.
    assign out_nxt = en_out & (~en_pwm | {PWM_CHANNELS{pwm_level}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out           <= '0;
            bus.period_strobe <= 1'b0;
        end else begin
            bus.out           <= out_nxt;
            bus.period_strobe <= wrap;
        end
    end
endmodule

// File: tb/tb_pwm_output_stage.sv
// Randomised bench for pwm_output_stage: two instances (CLK_DIV 4 and 1) checked every clk
// against a time-based reference model through per-instance expectation queues.
module tb_pwm_output_stage;
    localparam int NI = 2;
    localparam int DIVS [NI] = '{4, 1};

    typedef struct packed {
        logic [15:0] o;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] en_out = 16'h0;
    logic [15:0] en_pwm = 16'h0;
    logic [7:0]  duty_in = 8'h0;

    logic [15:0]   dut_out [NI];
    logic [NI-1:0] dut_strobe;

    int   chk = 0;
    int   fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   n_edges [NI];
    logic [7:0] shadow [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pwm_output_stage_if bus ();
        assign bus.en_reg_out_7_0  = en_out[7:0];
        assign bus.en_reg_out_15_8 = en_out[15:8];
        assign bus.en_reg_pwm_7_0  = en_pwm[7:0];
        assign bus.en_reg_pwm_15_8 = en_pwm[15:8];
        assign bus.pwm_duty_cycle  = duty_in;
        assign dut_out[g]    = bus.out;
        assign dut_strobe[g] = bus.period_strobe;

        pwm_output_stage #(.CLK_DIV(DIVS[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Reference model: edge n after reset release sees step floor((n-1)/D) mod 256,
    // and the strobe follows every 256*D-th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                n_edges[i] = 0;
                shadow[i]  = 8'h00;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int         step;
                logic [7:0] duty;
                logic       lvl;
                exp_t       e;
                n_edges[i] = n_edges[i] + 1;
                step = ((n_edges[i] - 1) / DIVS[i]) % 256;
`ifdef PWM_SHADOW_EN
                duty = shadow[i];
`else
                duty = duty_in;
`endif
                lvl = (duty == 8'hFF) || (step < int'(duty));
                for (int b = 0; b < 16; b++) begin
                    e.o[b] = en_out[b] && (en_pwm[b] ? lvl : 1'b1);
                end
                e.s = (n_edges[i] % (256 * DIVS[i])) == 0;
                if (e.s) shadow[i] = duty_in;
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    end

    function automatic void check(string name, int inst, logic [15:0] act, logic [15:0] exp);
        chk++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", name, inst, $time, act, exp);
        end
    endfunction

    // Monitor: outputs are sampled 1 time unit after each posedge and after async reset.
    always @(posedge clk or negedge rst_n) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                check("reset_out", i, dut_out[i], 16'h0000);
                check("reset_strobe", i, {15'h0, dut_strobe[i]}, 16'h0000);
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                logic have;
                have = 1'b0;
                e    = '0;
                if (i == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (i == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (have) begin
                    check("out", i, dut_out[i], e.o);
                    check("period_strobe", i, {15'h0, dut_strobe[i]}, {15'h0, e.s});
                end else begin
                    chk++;
                    fail++;
                    $display("FAIL no_expectation inst=%0d t=%0t", i, $time);
                end
            end
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] o, input logic [15:0] p, input logic [7:0] d);
        en_out  = o;
        en_pwm  = p;
        duty_in = d;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        set_in(16'hFFFF, 16'hFFFF, 8'hFF);
        run(3);
        rst_n = 1'b1;
        run(3);

        // Static on: no toggling over three periods of the slower instance.
        set_in(16'hA5C3, 16'h0000, 8'h37);
        run(3 * 1024);

        // Duty sweep across the boundary values.
        set_in(16'hFFFF, 16'hFFFF, 8'h00);
        run(1024);
        duty_in = 8'h80;
        run(1024);
        duty_in = 8'hFF;
        run(1024);

        // Mode mix: en_pwm without en_out must stay low.
        set_in(16'h00FF, 16'h0F0F, 8'h40);
        run(1024);

        // Randomised register writes at arbitrary points in the period.
        for (int k = 0; k < 20; k++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            set_in(16'($urandom), 16'($urandom), d);
            run($urandom_range(1, 600));
        end

        // Shadowed-duty scenario: duty change in the middle of a period.
        set_in(16'hFFFF, 16'hFFFF, 8'h20);
        run(1500);
        duty_in = 8'hE0;
        run(2100);

        // Async reset mid-period at step 150 of the CLK_DIV=4 instance.
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(150 * 4 + 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(1100);

        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end
endmodule
